fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single FIFO write port (WREQ/WD) between N_REQ producers.
- It grants one producer at a time for a bounded burst and forwards that producer's data word to WD.
- It throttles writes on the FIFO full flag f and sits directly in front of the FIFO write side, in the write clock domain.

Parameters:
N_REQ, 4, number of producers (2..8)
DW, 8, data width; matches FIFO WD width
MAX_BURST, 4, max words written per grant (1..16)

Ports:
clk  in  1  write-domain clock; connects to the FIFO clkw
rst  in  1  reset, asynchronous, active-high
req  in  N_REQ  per-producer request; held high while the producer has a word presented
req_data  in  N_REQ*DW  producer words, flattened; producer i uses bits [i*DW+DW-1 : i*DW]
f  in  1  FIFO full flag (combinational from FIFO pointers)
WREQ  out  1  FIFO write request
WD  out  DW  FIFO write data
gnt  out  N_REQ  one-hot current grant (all zero when idle)
ack  out  N_REQ  one-hot; ack[i]=1 means producer i's word is written this cycle, so the producer advances
busy  out  1  high in BURST state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, gnt=0, cnt=0, last=N_REQ-1. Consequently WREQ=0, WD=0, ack=0, busy=0.
- FSM states: IDLE, BURST. gnt, cnt and last are registers.
- IDLE:
  - If req!=0, select the first set bit searching upward from last+1, wrapping modulo N_REQ.
  - Load gnt with that one-hot value and set last to its index. Set cnt=0 and go to BURST.
  - If req==0, stay in IDLE.
  - Grant latency is 1 cycle from req rising to gnt.
- BURST, with g = granted index:
  - WREQ = req[g] & ~f (combinational).
  - WD = req_data slice g when WREQ=1, else 0.
  - ack = gnt when WREQ=1, else 0.
  - On each cycle with WREQ=1, cnt increments.
- BURST exit:
  - Go to IDLE and clear gnt when WREQ=1 and cnt==MAX_BURST-1 (burst complete).
  - Also go to IDLE when req[g]=0 (producer withdrew). No write occurs that cycle.
  - An exit always costs one IDLE cycle before the next grant. Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles under contention.
- Full:
  - f=1 in BURST holds state, gnt and cnt. WREQ=0 and ack=0.
  - Writing resumes the cycle f falls. The grant is not released while stalled.
- Fairness:
  - The next search starts after last, so a producer that just finished cannot win again while another req is pending.
  - A single requester may be re-granted after the IDLE bubble.
- Width rules: cnt is clog2(MAX_BURST)+1 bits and never exceeds MAX_BURST-1. Index arithmetic wraps modulo N_REQ.
- Simultaneous events:
  - Requests arriving during BURST are only sampled in IDLE.
  - If req[g] falls while f=1, exit to IDLE.
- Reset mid-burst: WREQ and ack drop immediately (asynchronous). A partially written burst is not resumed. last returns to N_REQ-1.
- Invariants: gnt is zero or one-hot. ack is a subset of gnt. WREQ == |ack.

Test Plan:
- Reset with req=4'b1111, f=0 → after release, gnt=4'b0001 one cycle later. ack[0] pulses 4 consecutive cycles with WD=req_data[7:0], then 1 IDLE cycle, then gnt=4'b0010.
- req=4'b0101 held constantly, f=0 → grant order 0,2,0,2. Each burst is 4 writes, with 1 idle cycle between bursts. 8 writes occur in 10 cycles.
- Grant to producer 1, req[1] drops after 2 acks → IDLE the next cycle, 2 words written, cnt reset. The next grant goes to the next requester above 1.
- During a burst to producer 3, f=1 for 3 cycles after the 2nd write → WREQ=0 and gnt=4'b1000 are held for those 3 cycles. The remaining 2 writes follow once f=0, for 4 writes total.
- rst pulsed high mid-burst (after 1 write) → WREQ, ack and gnt go to 0 asynchronously. After release with req=4'b0100, gnt=4'b0100 one cycle later.
- MAX_BURST=1, req=4'b1111 → grant order 0,1,2,3,0 with exactly one write per grant and alternating write/idle cycles.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between N_REQ producers, the arbiter and the FIFO write side.
//   req      : per-producer request, held while a word is presented
//   req_data : flattened producer words, producer i at [i*DW +: DW]
//   f        : FIFO full flag
//   WREQ/WD  : FIFO write request / write data
//   gnt      : one-hot current grant (zero when idle)
//   ack      : one-hot, producer whose word is written this cycle
//   busy     : arbiter is in a burst
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic                f;
    logic                WREQ;
    logic [DW-1:0]       WD;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    ack;
    logic                busy;

    // Arbiter side
    modport slave (
        input  req, req_data, f,
        output WREQ, WD, gnt, ack, busy
    );

    // Producer / FIFO side
    modport master (
        output req, req_data, f,
        input  WREQ, WD, gnt, ack, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// Grants one producer per burst of up to MAX_BURST words, stalls on full.
//   clk : write-domain clock
//   rst : asynchronous active-high reset
//   bus : fifo_wr_arbiter_if slave (req/req_data/f in; WREQ/WD/gnt/ack/busy out)
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wr_arbiter_if.slave      bus
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt,   w_gnt_nxt;
    logic [CW-1:0]    r_cnt,   w_cnt_nxt;
    logic [IW-1:0]    r_last,  w_last_nxt;

    logic             w_found;
    logic [IW-1:0]    w_sel;
    logic             w_req_g;
    logic             w_wr;

    // Index of base+off, wrapped modulo N_REQ
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        return IW'((32'(base) + off) % N_REQ);
    endfunction

    // Round-robin search: first requester strictly after the last grant
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!w_found && bus.req[wrap_idx(r_last, k)]) begin
                w_found = 1'b1;
                w_sel   = wrap_idx(r_last, k);
            end
        end
    end

    // In BURST, r_last holds the granted index
    assign w_req_g = bus.req[r_last];
    assign w_wr    = (r_state == BURST) && w_req_g && !bus.f;

    assign bus.WREQ = w_wr;
    assign bus.WD   = w_wr ? bus.req_data[32'(r_last)*DW +: DW] : '0;
    assign bus.ack  = w_wr ? r_gnt : '0;
    assign bus.gnt  = r_gnt;
    assign bus.busy = (r_state == BURST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_last  <= IW'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BURST;
                    w_gnt_nxt   = N_REQ'(1) << w_sel;
                    w_last_nxt  = w_sel;
                    w_cnt_nxt   = '0;
                end
            end
            BURST: begin
                // Withdrawal wins over a full stall; no write this cycle
                if (!w_req_g) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_wr) begin
                    if (r_cnt == CW'(MAX_BURST - 1)) begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one instance with MAX_BURST=4,
// one with MAX_BURST=1, sharing clock and reset.
module tb_fifo_wr_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 8;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus  ();
    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus1 ();

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_BURST(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_BURST(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int writes;

    logic [DW-1:0] dat  [N_REQ];
    logic [DW-1:0] dat1 [N_REQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse; released 1 time unit after an edge, so the next edge samples req
    task automatic do_reset(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] r1);
        rst      = 1'b1;
        bus.req  = r;
        bus1.req = r1;
        bus.f    = 1'b0;
        bus1.f   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        dat[0]  = 8'h11; dat[1]  = 8'h22; dat[2]  = 8'h33; dat[3]  = 8'h44;
        dat1[0] = 8'hA1; dat1[1] = 8'hB2; dat1[2] = 8'hC3; dat1[3] = 8'hD4;
        bus.req_data  = {dat[3], dat[2], dat[1], dat[0]};
        bus1.req_data = {dat1[3], dat1[2], dat1[1], dat1[0]};

        // Test 1: reset values, then first burst to producer 0, bubble, grant to 1
        rst = 1'b1; bus.req = 4'b1111; bus1.req = '0; bus.f = 1'b0; bus1.f = 1'b0;
        tick();
        check("rst_gnt",  32'(bus.gnt),  32'h0);
        check("rst_wreq", 32'(bus.WREQ), 32'h0);
        check("rst_wd",   32'(bus.WD),   32'h0);
        check("rst_ack",  32'(bus.ack),  32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_gnt1", 32'(bus1.gnt), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t1_gnt", 32'(bus.gnt),  32'h1);
        check("t1_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("t1_ack", 32'(bus.ack), 32'h1);
            check("t1_wd",  32'(bus.WD),  32'(dat[0]));
            tick();
        end
        check("t1_idle_wreq", 32'(bus.WREQ), 32'h0);
        check("t1_idle_gnt",  32'(bus.gnt),  32'h0);
        check("t1_idle_busy", 32'(bus.busy), 32'h0);
        tick();
        check("t1_gnt2", 32'(bus.gnt), 32'h2);
        check("t1_wd2",  32'(bus.WD),  32'(dat[1]));

        // Test 2: req=0101 held, grants alternate 0,2,0,2 with one idle cycle each
        do_reset(4'b0101, '0);
        writes = 0;
        begin
            int cyc;
            cyc = 0;
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < 4; i++) begin
                    tick(); cyc++;
                    check("t2_ack", 32'(bus.ack), (b % 2 == 0) ? 32'h1 : 32'h4);
                    check("t2_wd",  32'(bus.WD),  32'(dat[(b % 2 == 0) ? 0 : 2]));
                    if (bus.WREQ && cyc <= 10) writes++;
                end
                tick(); cyc++;
                check("t2_bubble", 32'(bus.WREQ), 32'h0);
            end
        end
        check("t2_writes_10cyc", 32'(writes), 32'd8);

        // Test 3: producer 1 withdraws after 2 writes; next grant goes to 3
        do_reset(4'b0010, '0);
        tick();
        check("t3_ack_w1", 32'(bus.ack), 32'h2);
        check("t3_wd_w1",  32'(bus.WD),  32'(dat[1]));
        tick();
        check("t3_ack_w2", 32'(bus.ack), 32'h2);
        bus.req = 4'b1001;
        #1;
        check("t3_drop_wreq", 32'(bus.WREQ), 32'h0);
        check("t3_drop_ack",  32'(bus.ack),  32'h0);
        tick();
        check("t3_idle_busy", 32'(bus.busy), 32'h0);
        check("t3_idle_gnt",  32'(bus.gnt),  32'h0);
        tick();
        check("t3_next_gnt", 32'(bus.gnt), 32'h8);

        // Test 4: full stall for 3 cycles after 2 writes to producer 3
        do_reset(4'b1000, '0);
        writes = 0;
        tick();
        check("t4_wd", 32'(bus.WD), 32'(dat[3]));
        if (bus.WREQ) writes++;
        tick();
        if (bus.WREQ) writes++;
        tick();
        bus.f = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_wreq", 32'(bus.WREQ), 32'h0);
            check("t4_stall_gnt",  32'(bus.gnt),  32'h8);
            check("t4_stall_ack",  32'(bus.ack),  32'h0);
            tick();
        end
        bus.f = 1'b0;
        #1;
        check("t4_resume", 32'(bus.WREQ), 32'h1);
        if (bus.WREQ) writes++;
        tick();
        if (bus.WREQ) writes++;
        tick();
        check("t4_end_gnt",   32'(bus.gnt),  32'h0);
        check("t4_end_wreq",  32'(bus.WREQ), 32'h0);
        check("t4_writes",    32'(writes),   32'd4);

        // Test 5: asynchronous reset after one write, then grant to producer 2
        do_reset(4'b1111, '0);
        tick();
        check("t5_gnt", 32'(bus.gnt), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        check("t5_async_wreq", 32'(bus.WREQ), 32'h0);
        check("t5_async_ack",  32'(bus.ack),  32'h0);
        check("t5_async_gnt",  32'(bus.gnt),  32'h0);
        bus.req = 4'b0100;
        tick();
        rst = 1'b0;
        tick();
        check("t5_regnt",    32'(bus.gnt), 32'h4);
        check("t5_regnt_wd", 32'(bus.WD),  32'(dat[2]));

        // Test 6: MAX_BURST=1 rotates 0,1,2,3,0 with write/idle alternation
        bus.req = '0;
        do_reset('0, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_gnt",  32'(bus1.gnt),  32'(4'b0001 << (k % 4)));
            check("t6_wreq", 32'(bus1.WREQ), 32'h1);
            check("t6_wd",   32'(bus1.WD),   32'(dat1[k % 4]));
            tick();
            check("t6_idle_wreq", 32'(bus1.WREQ), 32'h0);
            check("t6_idle_gnt",  32'(bus1.gnt),  32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
